// File: rtl/chip_config_shifter.sv
// chip_config_shifter: serializes one configuration word onto the speckle
// sensor's 3-wire interface (sclk, sdata, load). Every state advance is gated
// by the clock divider's tick, so the divider alone sets the serial bit rate.
module chip_config_shifter #(
    parameter int unsigned NB_DATA   = 16,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_sclk,
    output logic               o_sdata,
    output logic               o_load,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned CNT_W = $clog2(NB_DATA);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    logic [1:0]         state;
    logic [NB_DATA-1:0] shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [NB_DATA-1:0] shreg_next;
    logic               next_bit;

    // Shift toward the output end; next_bit is the bit that becomes current.
    always_comb begin
        if (LSB_FIRST) begin
            shreg_next = shreg >> 1;
            next_bit   = shreg[1];
        end else begin
            shreg_next = shreg << 1;
            next_bit   = shreg[NB_DATA-2];
        end
    end

    // Transfer FSM; all outputs are registered here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            o_sclk  <= 1'b0;
            o_sdata <= 1'b0;
            o_load  <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A tick coinciding with the start is deliberately ignored
                    // so data gets a full setup phase before the first edge.
                    if (i_start) begin
                        shreg   <= i_data;
                        bit_cnt <= CNT_W'(NB_DATA - 1);
                        o_sdata <= LSB_FIRST ? i_data[0] : i_data[NB_DATA-1];
                        o_busy  <= 1'b1;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (i_tick) begin
                        o_sclk <= 1'b1;
                        state  <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (i_tick) begin
                        o_sclk <= 1'b0;
                        if (bit_cnt == '0) begin
                            o_sdata <= 1'b0;
                            o_load  <= 1'b1;
                            state   <= ST_LATCH;
                        end else begin
                            shreg   <= shreg_next;
                            o_sdata <= next_bit;
                            bit_cnt <= bit_cnt - 1'b1;
                            state   <= ST_SETUP;
                        end
                    end
                end
                ST_LATCH: begin
                    if (i_tick) begin
                        o_load <= 1'b0;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
